// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the cache <-> main-memory line protocol.
package mem_if_pkg;

    localparam int WORD_W            = 32;
    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_LINE_SIZE     = 1 << DEF_LINE_ADDR_LEN;

    typedef logic [DEF_LINE_SIZE-1:0][WORD_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GNT  = 2'd2
    } mem_state_e;

    // Power-up image: word w of line L holds (L << line_addr_len) | w.
    function automatic logic [WORD_W-1:0] image_word(input int unsigned line_idx,
                                                     input int unsigned word_idx,
                                                     input int unsigned line_addr_len);
        return WORD_W'((line_idx << line_addr_len) | word_idx);
    endfunction

endpackage

// File: rtl/line_store.sv
// Line-wide synchronous single-port backing store; contents survive reset and
// start from a deterministic power-up image.
module line_store
    import mem_if_pkg::*;
#(
    parameter int ADDR_LEN      = 8,
    parameter int LINE_ADDR_LEN = 3
) (
    input  logic                                      clk,
    input  logic                                      we,
    input  logic [ADDR_LEN-1:0]                       addr,
    input  logic [(1<<LINE_ADDR_LEN)-1:0][WORD_W-1:0] wdata,
    output logic [(1<<LINE_ADDR_LEN)-1:0][WORD_W-1:0] rdata
);

    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int DEPTH     = 1 << ADDR_LEN;

    typedef logic [LINE_SIZE-1:0][WORD_W-1:0] word_line_t;

    function automatic word_line_t image_line(input int unsigned line_idx);
        word_line_t img;
        for (int w = 0; w < LINE_SIZE; w++) begin
            img[w] = image_word(line_idx, w, LINE_ADDR_LEN);
        end
        return img;
    endfunction

    word_line_t line_view [DEPTH];
    word_line_t rdata_q;

    for (genvar l = 0; l < DEPTH; l++) begin : g_line
        word_line_t line_q = image_line(l);

        always_ff @(posedge clk) begin
            if (we && addr == ADDR_LEN'(l)) begin
                line_q <= wdata;
            end
        end

        assign line_view[l] = line_q;
    end

    always_ff @(posedge clk) begin
        rdata_q <= line_view[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Slave end of the cache line protocol: services one whole-line read or write
// at a time after a programmable latency and answers with a one-cycle gnt.
module line_mem_responder
    import mem_if_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 8,
    parameter int RD_LATENCY    = 50,
    parameter int WR_LATENCY    = 50
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [ADDR_LEN-1:0]                       addr,
    input  logic                                      rd_req,
    input  logic                                      wr_req,
    input  logic [(1<<LINE_ADDR_LEN)-1:0][WORD_W-1:0] wr_line,
    output logic [(1<<LINE_ADDR_LEN)-1:0][WORD_W-1:0] rd_line,
    output logic                                      gnt,
    output logic [31:0]                               rd_cnt,
    output logic [31:0]                               wr_cnt
);

    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int MAX_LAT   = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W     = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

    typedef logic [LINE_SIZE-1:0][WORD_W-1:0] word_line_t;

    mem_state_e          state_q,   state_d;
    logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [ADDR_LEN-1:0] addr_q,    addr_d;
    logic                op_wr_q,   op_wr_d;
    word_line_t          wr_line_q, wr_line_d;
    word_line_t          rd_line_q, rd_line_d;
    logic                gnt_q,     gnt_d;
    logic [31:0]         rd_cnt_q,  rd_cnt_d;
    logic [31:0]         wr_cnt_q,  wr_cnt_d;

    logic                store_we;
    logic [ADDR_LEN-1:0] store_addr;
    word_line_t          store_rdata;

    // Reading straight from the live address while idle lets the store's
    // registered output be ready even when the latency is a single cycle.
    assign store_addr = (state_q == IDLE) ? addr : addr_q;

    line_store #(
        .ADDR_LEN      (ADDR_LEN),
        .LINE_ADDR_LEN (LINE_ADDR_LEN)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .addr  (store_addr),
        .wdata (wr_line_q),
        .rdata (store_rdata)
    );

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        addr_d    = addr_q;
        op_wr_d   = op_wr_q;
        wr_line_d = wr_line_q;
        rd_line_d = rd_line_q;
        gnt_d     = 1'b0;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        store_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    addr_d    = addr;
                    op_wr_d   = wr_req;
                    wr_line_d = wr_line;
                    lat_cnt_d = wr_req ? WR_LOAD : RD_LOAD;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (lat_cnt_q == '0) begin
                    if (op_wr_q) begin
                        store_we = 1'b1;
                    end else begin
                        rd_line_d = store_rdata;
                    end
                    gnt_d   = 1'b1;
                    state_d = GNT;
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                end
            end
            // Requests are deliberately not looked at here: the requester is
            // still holding its level request during the grant cycle.
            GNT: begin
                if (op_wr_q) begin
                    wr_cnt_d = wr_cnt_q + 32'd1;
                end else begin
                    rd_cnt_d = rd_cnt_q + 32'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            addr_q    <= '0;
            op_wr_q   <= 1'b0;
            wr_line_q <= '0;
            rd_line_q <= '0;
            gnt_q     <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            addr_q    <= addr_d;
            op_wr_q   <= op_wr_d;
            wr_line_q <= wr_line_d;
            rd_line_q <= rd_line_d;
            gnt_q     <= gnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign rd_line = rd_line_q;
    assign gnt     = gnt_q;
    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: scenario tasks checked against a line-array
// model of the backing store plus expected grant latencies.
module tb_line_mem_responder;

    localparam int AL      = 8;
    localparam int LAL     = 3;
    localparam int LS      = 1 << LAL;
    localparam int RD_LAT  = 4;
    localparam int WR_LAT  = 6;
    localparam int TIMEOUT = 200;

    typedef logic [LS-1:0][31:0] tb_line_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic        rd_req;
    logic        wr_req;
    tb_line_t    wr_line;
    tb_line_t    rd_line;
    logic        gnt;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int checks = 0;
    int errors = 0;

    tb_line_t    ref_mem [256];
    tb_line_t    exp_rd_line;
    logic [31:0] exp_rd_cnt;
    logic [31:0] exp_wr_cnt;

    always #5 clk = ~clk;

    line_mem_responder #(
        .LINE_ADDR_LEN (LAL),
        .ADDR_LEN      (AL),
        .RD_LATENCY    (RD_LAT),
        .WR_LATENCY    (WR_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .wr_line (wr_line),
        .rd_line (rd_line),
        .gnt     (gnt),
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt)
    );

    // ---------------- reference model ----------------
    task automatic model_init();
        for (int l = 0; l < 256; l++) begin
            for (int w = 0; w < LS; w++) begin
                ref_mem[l][w] = 32'(l * LS + w);
            end
        end
        exp_rd_line = '0;
        exp_rd_cnt  = '0;
        exp_wr_cnt  = '0;
    endtask

    task automatic model_op(input bit is_wr, input logic [7:0] a, input tb_line_t l);
        if (is_wr) begin
            ref_mem[a] = l;
            exp_wr_cnt = exp_wr_cnt + 32'd1;
        end else begin
            exp_rd_line = ref_mem[a];
            exp_rd_cnt  = exp_rd_cnt + 32'd1;
        end
    endtask

    function automatic tb_line_t rand_line();
        tb_line_t l;
        for (int k = 0; k < LS; k++) l[k] = $urandom();
        return l;
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic start_req(input bit w, input bit r, input logic [7:0] a, input tb_line_t l);
        wr_req  = w;
        rd_req  = r;
        addr    = a;
        wr_line = l;
    endtask

    // Counts falling edges from the driving edge until gnt is seen; -1 on timeout.
    task automatic wait_gnt(output int n);
        n = 0;
        repeat (TIMEOUT) begin
            @(negedge clk);
            n++;
            if (gnt === 1'b1) return;
        end
        n = -1;
    endtask

    // Requester keeps its request through the grant cycle and drops it after.
    task automatic end_req();
        @(negedge clk);
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        addr    = 8'($urandom());
        wr_line = rand_line();
    endtask

    task automatic do_op(input bit w, input bit r, input logic [7:0] a, input tb_line_t l,
                         output int n);
        start_req(w, r, a, l);
        wait_gnt(n);
        model_op(w, a, l);
        end_req();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start_req(1'b0, 1'b0, 8'h00, '0);
        model_init();
        repeat (3) @(negedge clk);
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", gnt); end
        checks++; if (rd_line !== '0) begin errors++; $display("FAIL reset_rd_line got %h exp 0", rd_line); end
        checks++; if (rd_cnt !== 32'd0) begin errors++; $display("FAIL reset_rd_cnt got %0d exp 0", rd_cnt); end
        checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL reset_wr_cnt got %0d exp 0", wr_cnt); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_basic();
        int n;
        do_op(1'b0, 1'b1, 8'h05, rand_line(), n);
        checks++; if (n !== RD_LAT + 1) begin errors++; $display("FAIL rd_latency got %0d exp %0d", n, RD_LAT + 1); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt_width got %b exp 0", gnt); end
        checks++; if (rd_line !== exp_rd_line) begin errors++; $display("FAIL rd_line_image got %h exp %h", rd_line, exp_rd_line); end
        checks++; if (rd_line[3] !== 32'h2B) begin errors++; $display("FAIL rd_word3 got %h exp 2b", rd_line[3]); end
        checks++; if (rd_cnt !== exp_rd_cnt) begin errors++; $display("FAIL rd_cnt got %0d exp %0d", rd_cnt, exp_rd_cnt); end
    endtask

    task automatic test_write_then_read();
        int n;
        tb_line_t l;
        for (int k = 0; k < LS; k++) l[k] = 32'hA0 + 32'(k);
        do_op(1'b1, 1'b0, 8'h05, l, n);
        checks++; if (n !== WR_LAT + 1) begin errors++; $display("FAIL wr_latency got %0d exp %0d", n, WR_LAT + 1); end
        checks++; if (rd_line !== exp_rd_line) begin errors++; $display("FAIL wr_keeps_rd_line got %h exp %h", rd_line, exp_rd_line); end
        checks++; if (wr_cnt !== exp_wr_cnt) begin errors++; $display("FAIL wr_cnt got %0d exp %0d", wr_cnt, exp_wr_cnt); end
        do_op(1'b0, 1'b1, 8'h05, rand_line(), n);
        checks++; if (n !== RD_LAT + 1) begin errors++; $display("FAIL rdback_latency got %0d exp %0d", n, RD_LAT + 1); end
        checks++; if (rd_line !== exp_rd_line) begin errors++; $display("FAIL rdback_line got %h exp %h", rd_line, exp_rd_line); end
    endtask

    task automatic test_hold_through_gnt();
        int n;
        int extra;
        do_op(1'b0, 1'b1, 8'($urandom()), rand_line(), n);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (gnt === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL hold_no_retrigger got %0d extra gnt exp 0", extra); end
        checks++; if (rd_cnt !== exp_rd_cnt) begin errors++; $display("FAIL hold_rd_cnt got %0d exp %0d", rd_cnt, exp_rd_cnt); end
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        logic [7:0] a;
        tb_line_t l;
        a = 8'($urandom());
        l = rand_line();
        start_req(1'b1, 1'b0, a, l);
        wait_gnt(n1);
        model_op(1'b1, a, l);
        @(negedge clk);
        start_req(1'b0, 1'b1, a, rand_line());
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL b2b_gnt_width got %b exp 0", gnt); end
        checks++; if (rd_line !== exp_rd_line) begin errors++; $display("FAIL b2b_rd_line_kept got %h exp %h", rd_line, exp_rd_line); end
        wait_gnt(n2);
        model_op(1'b0, a, l);
        end_req();
        checks++; if (n1 !== WR_LAT + 1) begin errors++; $display("FAIL b2b_wr_latency got %0d exp %0d", n1, WR_LAT + 1); end
        checks++; if (n2 !== RD_LAT + 1) begin errors++; $display("FAIL b2b_rd_latency got %0d exp %0d", n2, RD_LAT + 1); end
        checks++; if (rd_line !== exp_rd_line) begin errors++; $display("FAIL b2b_rd_line got %h exp %h", rd_line, exp_rd_line); end
    endtask

    task automatic test_both_requests();
        int n;
        tb_line_t l;
        l = rand_line();
        do_op(1'b1, 1'b1, 8'h10, l, n);
        checks++; if (n !== WR_LAT + 1) begin errors++; $display("FAIL both_latency got %0d exp %0d", n, WR_LAT + 1); end
        checks++; if (wr_cnt !== exp_wr_cnt) begin errors++; $display("FAIL both_wr_cnt got %0d exp %0d", wr_cnt, exp_wr_cnt); end
        checks++; if (rd_cnt !== exp_rd_cnt) begin errors++; $display("FAIL both_rd_cnt got %0d exp %0d", rd_cnt, exp_rd_cnt); end
        checks++; if (rd_line !== exp_rd_line) begin errors++; $display("FAIL both_rd_line got %h exp %h", rd_line, exp_rd_line); end
        do_op(1'b0, 1'b1, 8'h10, rand_line(), n);
        checks++; if (rd_line !== l) begin errors++; $display("FAIL both_written got %h exp %h", rd_line, l); end
    endtask

    task automatic test_capture_and_drop();
        int n;
        tb_line_t l;
        l = rand_line();
        start_req(1'b1, 1'b0, 8'h33, l);
        @(negedge clk);
        addr    = 8'h34;
        wr_line = rand_line();
        wait_gnt(n);
        model_op(1'b1, 8'h33, l);
        end_req();
        checks++; if (n + 1 !== WR_LAT + 1) begin errors++; $display("FAIL capture_latency got %0d exp %0d", n + 1, WR_LAT + 1); end
        do_op(1'b0, 1'b1, 8'h33, rand_line(), n);
        checks++; if (rd_line !== exp_rd_line) begin errors++; $display("FAIL capture_line got %h exp %h", rd_line, exp_rd_line); end
        do_op(1'b0, 1'b1, 8'h34, rand_line(), n);
        checks++; if (rd_line !== exp_rd_line) begin errors++; $display("FAIL capture_neighbour got %h exp %h", rd_line, exp_rd_line); end
        // Request withdrawn after one cycle: the read must still complete.
        start_req(1'b0, 1'b1, 8'h40, rand_line());
        @(negedge clk);
        rd_req = 1'b0;
        wait_gnt(n);
        model_op(1'b0, 8'h40, '0);
        checks++; if (n + 1 !== RD_LAT + 1) begin errors++; $display("FAIL drop_latency got %0d exp %0d", n + 1, RD_LAT + 1); end
        @(negedge clk);
        checks++; if (rd_line !== exp_rd_line) begin errors++; $display("FAIL drop_line got %h exp %h", rd_line, exp_rd_line); end
        checks++; if (rd_cnt !== exp_rd_cnt) begin errors++; $display("FAIL drop_rd_cnt got %0d exp %0d", rd_cnt, exp_rd_cnt); end
    endtask

    task automatic test_random();
        int n;
        bit w;
        bit r;
        logic [7:0] a;
        logic [7:0] pool [4];
        pool[0] = 8'h00; pool[1] = 8'hFF; pool[2] = 8'h21; pool[3] = 8'h80;
        for (int i = 0; i < 24; i++) begin
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            a = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : 8'($urandom());
            do_op(w, r, a, rand_line(), n);
            checks++; if (n !== (w ? WR_LAT + 1 : RD_LAT + 1)) begin errors++; $display("FAIL rnd_latency[%0d] got %0d wr=%0b", i, n, w); end
            checks++; if (rd_line !== exp_rd_line) begin errors++; $display("FAIL rnd_rd_line[%0d] got %h exp %h", i, rd_line, exp_rd_line); end
            checks++; if (rd_cnt !== exp_rd_cnt || wr_cnt !== exp_wr_cnt) begin
                errors++; $display("FAIL rnd_counts[%0d] got %0d/%0d exp %0d/%0d", i, rd_cnt, wr_cnt, exp_rd_cnt, exp_wr_cnt);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        int seen;
        start_req(1'b1, 1'b0, 8'h20, rand_line());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        start_req(1'b0, 1'b0, 8'h00, '0);
        exp_rd_line = '0;
        exp_rd_cnt  = '0;
        exp_wr_cnt  = '0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (WR_LAT + 4) begin
            @(negedge clk);
            if (gnt === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_gnt got %0d pulses exp 0", seen); end
        checks++; if (wr_cnt !== 32'd0 || rd_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_counts got %0d/%0d exp 0/0", rd_cnt, wr_cnt); end
        checks++; if (rd_line !== '0) begin errors++; $display("FAIL rstmid_rd_line got %h exp 0", rd_line); end
        do_op(1'b0, 1'b1, 8'h20, rand_line(), n);
        checks++; if (rd_line !== exp_rd_line) begin errors++; $display("FAIL rstmid_no_write got %h exp %h", rd_line, exp_rd_line); end
        checks++; if (rd_line[7] !== 32'h107) begin errors++; $display("FAIL rstmid_word7 got %h exp 107", rd_line[7]); end
        checks++; if (rd_cnt !== 32'd1) begin errors++; $display("FAIL rstmid_rd_cnt got %0d exp 1", rd_cnt); end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_then_read();
        test_hold_through_gnt();
        test_back_to_back();
        test_both_requests();
        test_capture_and_drop();
        test_random();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
